uart_rx_axis: RTL

Parametrised, oversampling UART receiver with an AXI4-Stream master output and a small receive FIFO. It replaces the single-rate receiver as the serial front end of the AXIS-UART bridge: it accepts 5–9 data bits, none/even/odd parity and 1 or 2 stop bits, and reports parity, framing, overrun and break conditions. Received frames are buffered so a stalled downstream does not immediately lose data.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_fifo.sv | 53 +++++
 rtl/uart_rx_axis.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, state encoding and helpers for the UART receive path.
// Rev 1.0
`default_nettype none

package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int FRAME_ERR_BIT  = 1;
  localparam int PARITY_ERR_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  function automatic int tick_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with wrap-bit pointers and an overrun pulse on a refused push.
// Rev 1.0
`default_nettype none

module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             accept;
  logic             do_pop;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign accept = push && (!full || do_pop);
  assign dout   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && !accept;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_axis.sv
// uart_rx_axis: oversampling UART receiver with parity/framing/break detection and AXI4-Stream output.
// Rev 1.0
`default_nettype none

module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic [1:0]           m_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int M        = OVERSAMPLE / 2;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam int BW       = $clog2(DATA_BITS);

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("uart_rx_axis: CLK_FREQ too low for BAUD * OVERSAMPLE");
  end

  logic                 sync1, rxs, rxs_d;
  logic [TW-1:0]        tick_cnt;
  logic                 tick, start_det, mid, bit_end, maj, last_stop;
  rx_state_t            state;
  logic [SW-1:0]        s_cnt;
  logic [1:0]           smp;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 par_bit, frame_err, fe_now, par_err, is_break;
  logic [1:0]           status;
  logic                 push;
  logic [DATA_BITS+1:0] push_data, fifo_dout;
  logic                 fifo_full, fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  assign start_det = (state == ST_IDLE) && rxs_d && !rxs;
  assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
  assign mid       = (s_cnt == SW'(M + 1));
  assign bit_end   = (s_cnt == SW'(OVERSAMPLE - 1));
  assign maj       = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    tick_cnt <= '0;
    else if (start_det || tick) tick_cnt <= '0;
    else                        tick_cnt <= tick_cnt + 1'b1;
  end

  // Frame status as it stands at the final stop-bit sample.
  always_comb begin
    fe_now   = frame_err | ~maj;
    par_err  = 1'b0;
    if (PARITY == PARITY_EVEN) par_err = (^shreg) != par_bit;
    if (PARITY == PARITY_ODD)  par_err = (^shreg) == par_bit;
    is_break = (shreg == '0) && ((PARITY == PARITY_NONE) || !par_bit) && fe_now;
    status   = '0;
    status[FRAME_ERR_BIT]  = fe_now;
    status[PARITY_ERR_BIT] = par_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      s_cnt     <= '0;
      smp       <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      par_bit   <= 1'b0;
      frame_err <= 1'b0;
      push      <= 1'b0;
      push_data <= '0;
      break_det <= 1'b0;
    end else begin
      push      <= 1'b0;
      break_det <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_det) begin
            state     <= ST_START;
            s_cnt     <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            frame_err <= 1'b0;
          end
        end
        ST_WAIT_IDLE: begin
          if (rxs) state <= ST_IDLE;
        end
        default: begin
          if (tick) begin
            s_cnt <= bit_end ? '0 : s_cnt + 1'b1;
            if (s_cnt == SW'(M - 1)) smp[0] <= rxs;
            if (s_cnt == SW'(M))     smp[1] <= rxs;
            if (mid) begin
              case (state)
                ST_START:  if (maj) state <= ST_IDLE;
                ST_DATA:   shreg <= {maj, shreg[DATA_BITS-1:1]};
                ST_PARITY: par_bit <= maj;
                ST_STOP: begin
                  // Leave mid-stop-bit so an immediately following start edge is caught.
                  if (last_stop) begin
                    if (is_break) begin
                      break_det <= 1'b1;
                      state     <= ST_WAIT_IDLE;
                    end else begin
                      push      <= 1'b1;
                      push_data <= {status, shreg};
                      state     <= fe_now ? ST_WAIT_IDLE : ST_IDLE;
                    end
                  end else begin
                    frame_err <= fe_now;
                  end
                end
                default: ;
              endcase
            end
            if (bit_end) begin
              case (state)
                ST_START: state <= ST_DATA;
                ST_DATA: begin
                  if (bit_cnt == BW'(DATA_BITS - 1)) begin
                    bit_cnt <= '0;
                    state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                  end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                  end
                end
                ST_PARITY: state <= ST_STOP;
                ST_STOP:   stop_cnt <= stop_cnt + 1'b1;
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .din     (push_data),
    .pop     (m_axis_tvalid && m_axis_tready),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .overrun (overrun)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_dout[DATA_BITS-1:0];
  assign m_axis_tuser  = fifo_dout[DATA_BITS+1:DATA_BITS];

endmodule

`default_nettype wire
